// File: rtl/nand_seq_alu_pkg.sv
// Shared definitions for the bit-serial NAND logic unit.
//   - op encodings (3 bits, 7 = illegal)
//   - sequencer state encoding
//   - op_steps(): NAND evaluations needed per result bit
//   - operand/destination select codes for the shared NAND cell mux
package nand_seq_pkg;

    localparam logic [2:0] OP_NAND = 3'd0;
    localparam logic [2:0] OP_AND  = 3'd1;
    localparam logic [2:0] OP_OR   = 3'd2;
    localparam logic [2:0] OP_NOR  = 3'd3;
    localparam logic [2:0] OP_XOR  = 3'd4;
    localparam logic [2:0] OP_XNOR = 3'd5;
    localparam logic [2:0] OP_NOTA = 3'd6;
    localparam logic [2:0] OP_ILL  = 3'd7;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    // Sources for the NAND cell inputs; T/U/V double as temporary destinations.
    typedef enum logic [2:0] {
        SEL_AI = 3'd0,
        SEL_BI = 3'd1,
        SEL_T  = 3'd2,
        SEL_U  = 3'd3,
        SEL_V  = 3'd4
    } sel_t;

    // Number of NAND evaluations per result bit for each op.
    function automatic logic [2:0] op_steps(input logic [2:0] op);
        case (op)
            OP_NAND: op_steps = 3'd1;
            OP_NOTA: op_steps = 3'd1;
            OP_AND:  op_steps = 3'd2;
            OP_OR:   op_steps = 3'd3;
            OP_NOR:  op_steps = 3'd4;
            OP_XOR:  op_steps = 3'd4;
            OP_XNOR: op_steps = 3'd5;
            default: op_steps = 3'd1;
        endcase
    endfunction

endpackage

// File: rtl/nand_seq_alu_nand2.sv
// Two-input NAND cell; the only logic evaluator used by nand_seq_alu.
//   a, b : inputs
//   y    : ~(a & b)
module nand2 (
    input  logic a,
    input  logic b,
    output logic y
);

    assign y = ~(a & b);

endmodule

// File: rtl/nand_seq_alu.sv
// Bit-serial logic unit: evaluates NAND/AND/OR/NOR/XOR/XNOR/NOTA on two
// WIDTH-bit operands with one shared nand2 cell, one evaluation per clock.
//   clk, rst_n : clock, synchronous active-low reset
//   start      : request, accepted when not busy (IDLE or DONE)
//   op, a, b   : operation and operands, latched on acceptance
//   busy       : high while evaluating
//   done       : one-cycle completion pulse
//   err        : set with done for op 7, cleared on next acceptance
//   y          : result, held until next acceptance
module nand_seq_alu
    import nand_seq_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic             err,
    output logic [WIDTH-1:0] y
);

    localparam int BW = $clog2(WIDTH);
    localparam logic [BW-1:0] LAST_BIT = BW'(WIDTH - 1);

    state_t           state_r, state_s;
    logic [WIDTH-1:0] a_r, b_r, y_r;
    logic [2:0]       op_r, step_r;
    logic [BW-1:0]    bit_r;
    logic             t_r, u_r, v_r;
    logic             busy_r, done_r, err_r;

    logic             accept_s, last_step_s, last_bit_s;
    sel_t             sel_a_s, sel_b_s, dst_s;
    logic             nand_a_s, nand_b_s, nand_y_s;

    function automatic logic pick(input sel_t sel, input logic ai, input logic bi,
                                  input logic t, input logic u, input logic v);
        case (sel)
            SEL_AI:  pick = ai;
            SEL_BI:  pick = bi;
            SEL_T:   pick = t;
            SEL_U:   pick = u;
            SEL_V:   pick = v;
            default: pick = 1'b0;
        endcase
    endfunction

    // Acceptance and end-of-sequence conditions.
    always_comb begin
        accept_s    = start && (state_r != ST_RUN);
        last_step_s = (step_r == 3'(op_steps(op_r) - 3'd1));
        last_bit_s  = (bit_r == LAST_BIT);
    end

    // Step decode: NAND input selects and temporary destination per op/step.
    always_comb begin
        sel_a_s = SEL_AI;
        sel_b_s = SEL_BI;
        dst_s   = SEL_T;
        case (op_r)
            OP_NAND: begin
                sel_a_s = SEL_AI; sel_b_s = SEL_BI;
            end
            OP_NOTA: begin
                sel_a_s = SEL_AI; sel_b_s = SEL_AI;
            end
            OP_AND: begin
                case (step_r)
                    3'd0:    begin sel_a_s = SEL_AI; sel_b_s = SEL_BI; dst_s = SEL_T; end
                    default: begin sel_a_s = SEL_T;  sel_b_s = SEL_T;  end
                endcase
            end
            OP_OR, OP_NOR: begin
                // NOR reuses the OR sequence, landing the OR in t before inverting.
                case (step_r)
                    3'd0:    begin sel_a_s = SEL_AI; sel_b_s = SEL_AI; dst_s = SEL_T; end
                    3'd1:    begin sel_a_s = SEL_BI; sel_b_s = SEL_BI; dst_s = SEL_U; end
                    3'd2:    begin sel_a_s = SEL_T;  sel_b_s = SEL_U;  dst_s = SEL_T; end
                    default: begin sel_a_s = SEL_T;  sel_b_s = SEL_T;  end
                endcase
            end
            OP_XOR, OP_XNOR: begin
                // XNOR reuses the XOR sequence, landing the XOR in t before inverting.
                case (step_r)
                    3'd0:    begin sel_a_s = SEL_AI; sel_b_s = SEL_BI; dst_s = SEL_T; end
                    3'd1:    begin sel_a_s = SEL_AI; sel_b_s = SEL_T;  dst_s = SEL_U; end
                    3'd2:    begin sel_a_s = SEL_BI; sel_b_s = SEL_T;  dst_s = SEL_V; end
                    3'd3:    begin sel_a_s = SEL_U;  sel_b_s = SEL_V;  dst_s = SEL_T; end
                    default: begin sel_a_s = SEL_T;  sel_b_s = SEL_T;  end
                endcase
            end
            default: begin
                sel_a_s = SEL_AI; sel_b_s = SEL_BI;
            end
        endcase
    end

    // Step-indexed operand mux feeding the shared cell.
    always_comb begin
        nand_a_s = pick(sel_a_s, a_r[bit_r], b_r[bit_r], t_r, u_r, v_r);
        nand_b_s = pick(sel_b_s, a_r[bit_r], b_r[bit_r], t_r, u_r, v_r);
    end

    nand2 u_nand2 (
        .a (nand_a_s),
        .b (nand_b_s),
        .y (nand_y_s)
    );

    // Next-state logic.
    always_comb begin
        state_s = state_r;
        case (state_r)
            ST_IDLE, ST_DONE: begin
                if (accept_s) begin
                    state_s = (op == OP_ILL) ? ST_DONE : ST_RUN;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_RUN: begin
                if (last_step_s && last_bit_s) begin
                    state_s = ST_DONE;
                end else begin
                    state_s = ST_RUN;
                end
            end
            default: state_s = ST_IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Datapath: operand latch, counters, temporaries, result and status flags.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            a_r    <= '0;
            b_r    <= '0;
            op_r   <= 3'd0;
            step_r <= 3'd0;
            bit_r  <= '0;
            t_r    <= 1'b0;
            u_r    <= 1'b0;
            v_r    <= 1'b0;
            y_r    <= '0;
            busy_r <= 1'b0;
            done_r <= 1'b0;
            err_r  <= 1'b0;
        end else if (state_r == ST_RUN) begin
            if (last_step_s) begin
                y_r[bit_r] <= nand_y_s;
                step_r     <= 3'd0;
                if (last_bit_s) begin
                    busy_r <= 1'b0;
                    done_r <= 1'b1;
                end else begin
                    bit_r <= bit_r + 1'b1;
                end
            end else begin
                step_r <= step_r + 3'd1;
                case (dst_s)
                    SEL_T:   t_r <= nand_y_s;
                    SEL_U:   u_r <= nand_y_s;
                    SEL_V:   v_r <= nand_y_s;
                    default: t_r <= nand_y_s;
                endcase
            end
        end else if (accept_s) begin
            a_r    <= a;
            b_r    <= b;
            op_r   <= op;
            step_r <= 3'd0;
            bit_r  <= '0;
            y_r    <= '0;
            busy_r <= (op != OP_ILL);
            done_r <= (op == OP_ILL);
            err_r  <= (op == OP_ILL);
        end else begin
            busy_r <= 1'b0;
            done_r <= 1'b0;
        end
    end

    assign busy = busy_r;
    assign done = done_r;
    assign err  = err_r;
    assign y    = y_r;

endmodule
